set_scan_ctrl: RTL and testbench
================================

Name: set_scan_ctrl

Overview:
- Sequencer for the SET candidate-counting engine.
- On a start request it loads the input buffer, which holds the circle centres and radii.
- It then walks every point of a GRID x GRID lattice, one point per cycle, and drives each point's coordinates to the distance datapath.
- It combines the per-circle hit flags according to the captured mode, accumulates the candidate count, then publishes the result and clears the buffer.

Parameters:
GRID, 8, lattice dimension; coordinates run 1..GRID on both axes; must satisfy GRID <= 2**COORD_W - 1
COORD_W, 4, width of x_o / y_o
CNT_W, 7, width of candidate_o; must be >= clog2(GRID*GRID+1)

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  start request; sampled only in IDLE
mode_i  in  2  counting mode; captured on start
hit_a_i  in  1  current point (x_o,y_o) lies inside circle A; combinational from datapath, valid in the same cycle
hit_b_i  in  1  current point lies inside circle B
hit_c_i  in  1  current point lies inside circle C
buffer_en_o  out  1  buffer load strobe; combinational = (state==IDLE) & en_i
clear_o  out  1  buffer clear strobe; registered
x_o  out  COORD_W  current point x
y_o  out  COORD_W  current point y
busy_o  out  1  high from the cycle after start through the DONE cycle
valid_o  out  1  one-cycle pulse; candidate_o is final
candidate_o  out  CNT_W  candidate count

Behaviour:
- Reset (async, any state): state=IDLE; x_o=0; y_o=0; busy_o=0; valid_o=0; clear_o=0; candidate_o=0; captured mode=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - buffer_en_o follows en_i combinationally, so the buffer captures its inputs on the same edge that accepts the start.
  - On en_i=1 at the edge: mode_r<=mode_i; x_o<=1; y_o<=1; candidate_o<=0; busy_o<=1; go to SCAN.
  - On en_i=0: hold state. candidate_o holds its last result.
- SCAN:
  - Each cycle, evaluate hit = f(mode_r, hit_a_i, hit_b_i, hit_c_i) for the current (x_o,y_o), then candidate_o <= candidate_o + hit.
  - mode 0: A only.
  - mode 1: A & B.
  - mode 2: A ^ B.
  - mode 3: exactly two of {A,B,C}, i.e. (A+B+C)==2.
  - Scan order is x inner, y outer. If x_o<GRID, x_o++. Otherwise x_o<=1 and y_o++.
  - At (GRID,GRID): accumulate that point, then go to DONE.
  - Exactly GRID*GRID SCAN cycles. Count range is 0..GRID*GRID with no wrap.
  - en_i and mode_i are ignored while in SCAN and DONE. buffer_en_o=0 outside IDLE.
- DONE (one cycle):
  - valid_o=1 and clear_o=1, both registered, asserted in this cycle only.
  - busy_o stays 1.
  - x_o=0 and y_o=0.
  - Next state is IDLE; busy_o, valid_o and clear_o drop to 0.
- Latency: start accepted at edge E0. Points occupy cycles 1..GRID*GRID. valid_o is high in cycle GRID*GRID+1 (cycle 65 for GRID=8).
- Back-to-back: if en_i is high in the first IDLE cycle after DONE, a new run starts immediately. Minimum period is GRID*GRID+2 cycles.
- Clear vs load: clear_o (DONE) and buffer_en_o (IDLE) are never high in the same cycle.
- Hit flags outside SCAN are ignored.
- Reset during SCAN or DONE: immediate return to reset values. No valid_o pulse. The partial count is discarded.

Test Plan:
- Mode 0, A at (4,4) r=2, hits from bench circle model (dx²+dy²<=r²) -> after one en_i pulse, valid_o pulses exactly 65 cycles later with candidate_o=13; clear_o high in the same cycle; buffer_en_o high only in the start cycle.
- Modes 1/2/3 with A=B=(4,4) r=2, C=(1,1) r=0 -> mode1=13, mode2=0, mode3=13.
- hit_a_i tied to 1, mode 0 -> candidate_o=64, no overflow. hit_a_i tied to 0 -> 0. Check the x_o/y_o sequence (1,1),(2,1)..(8,1),(1,2)..(8,8) with no repeats or gaps.
- en_i held high continuously -> consecutive valid_o pulses every 66 cycles. mode_i toggled mid-scan has no effect on the result. en_i during SCAN is not re-accepted.
- rst_i asserted asynchronously at the 30th SCAN point -> all outputs 0 immediately, no valid_o. A subsequent start gives the correct full count.

Source files
------------

// File: rtl/set_scan_ctrl.sv
// Sequencer for the SET candidate-counting engine: loads the circle buffer, walks a GRID x GRID
// lattice one point per cycle, accumulates mode-combined hit flags, then publishes and clears.
module set_scan_ctrl #(
  parameter int GRID    = 8,
  parameter int COORD_W = 4,
  parameter int CNT_W   = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [1:0]         mode_i,
  input  logic               hit_a_i,
  input  logic               hit_b_i,
  input  logic               hit_c_i,
  output logic               buffer_en_o,
  output logic               clear_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               busy_o,
  output logic               valid_o,
  output logic [CNT_W-1:0]   candidate_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COORD_W-1:0] GRID_C = COORD_W'(GRID);
  localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);

  state_t      state;
  logic [1:0]  mode_r;
  logic [1:0]  hit_sum;
  logic        hit;

  // The buffer latches its inputs on the same edge that accepts the start.
  assign buffer_en_o = (state == IDLE) && en_i;

  assign hit_sum = {1'b0, hit_a_i} + {1'b0, hit_b_i} + {1'b0, hit_c_i};

  always_comb begin
    hit = 1'b0;
    case (mode_r)
      2'd0:    hit = hit_a_i;
      2'd1:    hit = hit_a_i & hit_b_i;
      2'd2:    hit = hit_a_i ^ hit_b_i;
      default: hit = (hit_sum == 2'd2);
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mode_r      <= 2'd0;
      x_o         <= '0;
      y_o         <= '0;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      clear_o     <= 1'b0;
      candidate_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          clear_o <= 1'b0;
          busy_o  <= 1'b0;
          if (en_i) begin
            mode_r      <= mode_i;
            x_o         <= ONE_C;
            y_o         <= ONE_C;
            candidate_o <= '0;
            busy_o      <= 1'b1;
            state       <= SCAN;
          end
        end

        SCAN: begin
          // Count never exceeds GRID*GRID, which CNT_W is sized to hold.
          candidate_o <= candidate_o + CNT_W'(hit);
          if (x_o < GRID_C) begin
            x_o <= x_o + ONE_C;
          end else if (y_o < GRID_C) begin
            x_o <= ONE_C;
            y_o <= y_o + ONE_C;
          end else begin
            x_o     <= '0;
            y_o     <= '0;
            valid_o <= 1'b1;
            clear_o <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          valid_o <= 1'b0;
          clear_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          valid_o <= 1'b0;
          clear_o <= 1'b0;
          busy_o  <= 1'b0;
          x_o     <= '0;
          y_o     <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Bench for set_scan_ctrl: circle-model hit generator plus an arithmetic lattice reference count.
module tb_set_scan_ctrl;

  localparam int GRID    = 8;
  localparam int COORD_W = 4;
  localparam int CNT_W   = 7;
  localparam int NPTS    = GRID * GRID;

  logic               clk_i;
  logic               rst_i;
  logic               en_i;
  logic [1:0]         mode_i;
  logic               hit_a_i, hit_b_i, hit_c_i;
  logic               buffer_en_o, clear_o, busy_o, valid_o;
  logic [COORD_W-1:0] x_o, y_o;
  logic [CNT_W-1:0]   candidate_o;

  int n_chk  = 0;
  int n_fail = 0;

  int ax, ay, ar, bx, by, br, cx, cy, cr;
  int force_a;  // 0: circle model, 1: tie high, 2: tie low

  set_scan_ctrl #(.GRID(GRID), .COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i),
    .hit_a_i(hit_a_i), .hit_b_i(hit_b_i), .hit_c_i(hit_c_i),
    .buffer_en_o(buffer_en_o), .clear_o(clear_o), .x_o(x_o), .y_o(y_o),
    .busy_o(busy_o), .valid_o(valid_o), .candidate_o(candidate_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic bit in_circ(int x, int y, int ccx, int ccy, int r);
    return ((x - ccx) * (x - ccx) + (y - ccy) * (y - ccy)) <= r * r;
  endfunction

  always_comb begin
    hit_a_i = (force_a == 1) ? 1'b1 : (force_a == 2) ? 1'b0 : in_circ(int'(x_o), int'(y_o), ax, ay, ar);
    hit_b_i = in_circ(int'(x_o), int'(y_o), bx, by, br);
    hit_c_i = in_circ(int'(x_o), int'(y_o), cx, cy, cr);
  end

  function automatic int ref_count(int m);
    int n = 0;
    for (int y = 1; y <= GRID; y++)
      for (int x = 1; x <= GRID; x++) begin
        int a = in_circ(x, y, ax, ay, ar);
        int b = in_circ(x, y, bx, by, br);
        int c = in_circ(x, y, cx, cy, cr);
        case (m)
          0:       n += a;
          1:       n += a & b;
          2:       n += a ^ b;
          default: n += ((a + b + c) == 2) ? 1 : 0;
        endcase
      end
    return n;
  endfunction

  task automatic set_circles(int a_x, int a_y, int a_r, int b_x, int b_y, int b_r,
                             int c_x, int c_y, int c_r);
    ax = a_x; ay = a_y; ar = a_r;
    bx = b_x; by = b_y; br = b_r;
    cx = c_x; cy = c_y; cr = c_r;
  endtask

  // Runs one scan from IDLE and reports what was observed; the callers do the judging.
  task automatic do_run(input logic [1:0] m, input bit keep_en, input bit wiggle,
                        output int lat, output int cand, output int seq_err, output int aux_err);
    lat = -1; cand = -1; seq_err = 0; aux_err = 0;
    @(negedge clk_i);
    mode_i = m; en_i = 1'b1;
    #1;
    if (buffer_en_o !== 1'b1 || busy_o !== 1'b0) aux_err++;
    @(negedge clk_i);
    if (!keep_en) en_i = 1'b0;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      if (wiggle) mode_i = 2'($urandom);
      #1;
      if (buffer_en_o !== 1'b0 || busy_o !== 1'b1) aux_err++;
      if (k <= NPTS) begin
        if (x_o !== COORD_W'((k - 1) % GRID + 1) || y_o !== COORD_W'((k - 1) / GRID + 1)) seq_err++;
      end
      if (valid_o === 1'b1) begin
        lat  = k;
        cand = int'(candidate_o);
        if (clear_o !== 1'b1 || x_o !== '0 || y_o !== '0) aux_err++;
        en_i = 1'b0;
      end else if (clear_o !== 1'b0) begin
        aux_err++;
      end
      @(negedge clk_i);
    end
    mode_i = m; en_i = 1'b0;
    #1;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || clear_o !== 1'b0) aux_err++;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; en_i = 1'b0; mode_i = 2'd0;
    #1;
    n_chk++;
    if ({x_o, y_o, busy_o, valid_o, clear_o, candidate_o, buffer_en_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: x=%0d y=%0d busy=%b valid=%b clear=%b cand=%0d ben=%b, want all 0",
               x_o, y_o, busy_o, valid_o, clear_o, candidate_o, buffer_en_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_mode0;
    int lat, cand, se, ae;
    force_a = 0;
    set_circles(4, 4, 2, 0, 0, 0, 0, 0, 0);
    do_run(2'd0, 1'b0, 1'b0, lat, cand, se, ae);
    n_chk++;
    if (lat !== 65) begin n_fail++; $display("FAIL mode0_latency: got %0d want 65", lat); end
    n_chk++;
    if (cand !== 13) begin n_fail++; $display("FAIL mode0_count: got %0d want 13", cand); end
    n_chk++;
    if (ae !== 0) begin n_fail++; $display("FAIL mode0_strobes: %0d strobe/busy errors, want 0", ae); end
  endtask

  task automatic test_modes;
    int lat, cand, se, ae;
    int want[4] = '{0, 13, 0, 13};
    force_a = 0;
    set_circles(4, 4, 2, 4, 4, 2, 1, 1, 0);
    for (int m = 1; m <= 3; m++) begin
      do_run(2'(m), 1'b0, 1'b0, lat, cand, se, ae);
      n_chk++;
      if (cand !== want[m] || lat !== 65) begin
        n_fail++;
        $display("FAIL mode%0d_count: got %0d (lat %0d) want %0d (lat 65)", m, cand, lat, want[m]);
      end
    end
  endtask

  task automatic test_tied;
    int lat, cand, se, ae;
    force_a = 1;
    do_run(2'd0, 1'b0, 1'b0, lat, cand, se, ae);
    n_chk++;
    if (cand !== NPTS) begin n_fail++; $display("FAIL tied_high_count: got %0d want %0d", cand, NPTS); end
    n_chk++;
    if (se !== 0) begin n_fail++; $display("FAIL scan_sequence: %0d coordinate errors, want 0", se); end
    force_a = 2;
    do_run(2'd0, 1'b0, 1'b0, lat, cand, se, ae);
    n_chk++;
    if (cand !== 0) begin n_fail++; $display("FAIL tied_low_count: got %0d want 0", cand); end
    force_a = 0;
  endtask

  task automatic test_mode_ignore;
    int lat, cand, se, ae, expv;
    force_a = 0;
    set_circles(3, 5, 3, 5, 4, 2, 6, 6, 2);
    expv = ref_count(3);
    do_run(2'd3, 1'b1, 1'b1, lat, cand, se, ae);
    n_chk++;
    if (cand !== expv || lat !== 65) begin
      n_fail++;
      $display("FAIL mode_held_during_scan: got %0d (lat %0d) want %0d (lat 65)", cand, lat, expv);
    end
    n_chk++;
    if (ae !== 0) begin n_fail++; $display("FAIL en_during_scan_strobes: %0d errors, want 0", ae); end
  endtask

  task automatic test_back_to_back;
    int last, pulses, expv;
    bit ovl;
    force_a = 0;
    set_circles(5, 3, 3, 0, 0, 0, 0, 0, 0);
    expv = ref_count(0);
    last = -1; pulses = 0; ovl = 1'b0;
    @(negedge clk_i);
    mode_i = 2'd0; en_i = 1'b1;
    for (int k = 0; k < 3 * 66 + 10; k++) begin
      #1;
      if (clear_o && buffer_en_o) ovl = 1'b1;
      if (valid_o === 1'b1) begin
        n_chk++;
        if (candidate_o !== CNT_W'(expv)) begin
          n_fail++; $display("FAIL b2b_count: got %0d want %0d", candidate_o, expv);
        end
        if (last >= 0) begin
          n_chk++;
          if (k - last !== 66) begin
            n_fail++; $display("FAIL b2b_period: got %0d want 66", k - last);
          end
        end
        pulses++;
        last = k;
      end
      @(negedge clk_i);
    end
    en_i = 1'b0;
    repeat (70) @(negedge clk_i);
    n_chk++;
    if (pulses !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    n_chk++;
    if (ovl !== 1'b0) begin n_fail++; $display("FAIL clear_load_overlap: got %b want 0", ovl); end
  endtask

  task automatic test_reset_mid_scan;
    int lat, cand, se, ae, vcount;
    force_a = 0;
    set_circles(4, 4, 2, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    mode_i = 2'd0; en_i = 1'b1;
    @(negedge clk_i);
    en_i = 1'b0;
    repeat (29) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    n_chk++;
    if ({x_o, y_o, busy_o, valid_o, clear_o, candidate_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: x=%0d y=%0d busy=%b valid=%b clear=%b cand=%0d, want all 0",
               x_o, y_o, busy_o, valid_o, clear_o, candidate_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    vcount = 0;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (valid_o !== 1'b0 || busy_o !== 1'b0) vcount++;
      @(negedge clk_i);
    end
    n_chk++;
    if (vcount !== 0) begin n_fail++; $display("FAIL no_valid_after_reset: got %0d active cycles want 0", vcount); end
    do_run(2'd0, 1'b0, 1'b0, lat, cand, se, ae);
    n_chk++;
    if (cand !== 13 || lat !== 65) begin
      n_fail++; $display("FAIL restart_after_reset: got %0d (lat %0d) want 13 (lat 65)", cand, lat);
    end
  endtask

  task automatic test_random;
    int lat, cand, se, ae, expv, m;
    force_a = 0;
    for (int i = 0; i < 6; i++) begin
      set_circles(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), int'($urandom_range(0, 4)),
                  int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), int'($urandom_range(0, 4)),
                  int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), int'($urandom_range(0, 4)));
      m = int'($urandom_range(0, 3));
      expv = ref_count(m);
      do_run(2'(m), 1'b0, 1'b0, lat, cand, se, ae);
      n_chk++;
      if (cand !== expv || lat !== 65 || se !== 0 || ae !== 0) begin
        n_fail++;
        $display("FAIL random_run%0d: mode %0d got %0d (lat %0d seq %0d aux %0d) want %0d (lat 65, 0, 0)",
                 i, m, cand, lat, se, ae, expv);
      end
    end
  endtask

  initial begin
    force_a = 0;
    set_circles(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_mode0();
    test_modes();
    test_tied();
    test_mode_ignore();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
